// File: rtl/decoder_n_stream.sv
// Registered N-to-2^N one-hot decoder with valid/ready on both sides.
// Emits one handshake-gated beat per line for single, linear-sweep and wrap-sweep requests.
module decoder_n_stream #(
  parameter int unsigned SEL_W      = 3,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(2**SEL_W)-1:0] out_y,
  output logic [SEL_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic                  err
);
  localparam int unsigned OUT_W = 2**SEL_W;
  localparam logic [SEL_W-1:0] MAX_IDX = '1;

  typedef enum logic [1:0] {IDLE, SINGLE, SWEEP, WRAP} state_t;

  state_t             r_state, w_state_n;
  logic               r_valid, w_valid_n;
  logic               r_last,  w_last_n;
  logic               r_err,   w_err_n;
  logic [SEL_W-1:0]   r_idx,   w_idx_n;
  logic [SEL_W-1:0]   r_cnt,   w_cnt_n;
  logic [OUT_W-1:0]   r_y,     w_y_n;
  logic               w_beat;
  logic               w_idle;

  assign w_idle = (r_state == IDLE);
  assign w_beat = r_valid & out_ready;

  always_comb begin
    w_state_n = r_state;
    w_valid_n = r_valid;
    w_last_n  = r_last;
    w_idx_n   = r_idx;
    w_cnt_n   = r_cnt;
    w_err_n   = 1'b0;
    if (flush) begin
      // abort; out_idx deliberately keeps its value
      w_state_n = IDLE;
      w_valid_n = 1'b0;
      w_last_n  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            w_valid_n = 1'b1;
            w_idx_n   = in_sel;
            w_cnt_n   = MAX_IDX;
            case (in_mode)
              2'd1: begin
                w_state_n = SWEEP;
                w_last_n  = (in_sel == MAX_IDX);
              end
              2'd2: begin
                w_state_n = WRAP;
                w_last_n  = (SEL_W == 0);
              end
              default: begin
                w_state_n = SINGLE;
                w_last_n  = 1'b1;
                w_err_n   = (in_mode == 2'd3);
              end
            endcase
          end
        end
        SINGLE: begin
          if (w_beat) begin
            w_state_n = IDLE;
            w_valid_n = 1'b0;
            w_last_n  = 1'b0;
          end
        end
        SWEEP: begin
          if (w_beat) begin
            if (r_last) begin
              w_state_n = IDLE;
              w_valid_n = 1'b0;
              w_last_n  = 1'b0;
            end else begin
              w_idx_n  = r_idx + 1'b1;
              w_last_n = ((r_idx + 1'b1) == MAX_IDX);
            end
          end
        end
        WRAP: begin
          if (w_beat) begin
            if (r_last) begin
              w_state_n = IDLE;
              w_valid_n = 1'b0;
              w_last_n  = 1'b0;
            end else begin
              // index wraps naturally at SEL_W bits
              w_idx_n  = r_idx + 1'b1;
              w_cnt_n  = r_cnt - 1'b1;
              w_last_n = ((r_cnt - 1'b1) == '0);
            end
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    w_y_n = '0;
    if (w_valid_n) w_y_n[w_idx_n] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_n;
      r_valid <= w_valid_n;
      r_last  <= w_last_n;
      r_err   <= w_err_n;
      r_idx   <= w_idx_n;
      r_cnt   <= w_cnt_n;
      r_y     <= w_y_n;
    end
  end

  assign in_ready  = w_idle & ~flush;
  assign busy      = ~w_idle;
  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign out_last  = r_last;
  assign err       = r_err;
  assign out_y     = ACTIVE_LOW ? ~r_y : r_y;
endmodule
